// File: rtl/dff_chain_ctrl.sv
// dff_chain_ctrl: sequencer for a DEPTH x WIDTH shift-register window chain.
// Accepts samples over valid/ready, drives the chain shift enable and data,
// and raises win_valid when a full window (first fill) or a new STRIDE of
// samples is in the chain, freezing the chain until the consumer acknowledges.
// Optional macro ZERO_FLUSH_EN: clear zero-fills the chain for DEPTH cycles
// (FLUSH state) before filling resumes.
module dff_chain_ctrl #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int STRIDE = 16,
    parameter int CNT_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             shift_en,
    output logic [WIDTH-1:0] shift_data,
    output logic             win_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] fill_cnt,
    output logic [7:0]       win_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_HOLD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STRIDE_C = CNT_W'(STRIDE);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
    logic             first_q, first_d;
    logic [7:0]       win_count_q, win_count_d;

    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] fill_inc;
    logic             accept;

    // State register and counters, cleared asynchronously by active-low rst
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_FILL;
            fill_cnt_q  <= '0;
            first_q     <= 1'b1;
            win_count_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            first_q     <= first_d;
            win_count_q <= win_count_d;
        end
    end

    // Next-state logic: clear overrides any final accept or acknowledge
    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        first_d     = first_q;
        win_count_d = win_count_q;
        target      = first_q ? DEPTH_C : STRIDE_C;
        fill_inc    = fill_cnt_q + CNT_W'(1);
        accept      = in_valid & in_ready;

        if (clear) begin
`ifdef ZERO_FLUSH_EN
            state_d = S_FLUSH;
`else
            state_d = S_FILL;
`endif
            fill_cnt_d = '0;
            first_d    = 1'b1;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (accept) begin
                        if (fill_inc == target) begin
                            fill_cnt_d = target;
                            state_d    = S_HOLD;
                        end else begin
                            fill_cnt_d = fill_inc;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state_d     = S_FILL;
                        fill_cnt_d  = '0;
                        first_d     = 1'b0;
                        win_count_d = win_count_q + 8'd1;
                    end
                end
`ifdef ZERO_FLUSH_EN
                S_FLUSH: begin
                    // fill_cnt doubles as the flush counter
                    if (fill_inc == DEPTH_C) begin
                        state_d    = S_FILL;
                        fill_cnt_d = '0;
                        first_d    = 1'b1;
                    end else begin
                        fill_cnt_d = fill_inc;
                    end
                end
`endif
                default: begin
                    state_d    = S_FILL;
                    fill_cnt_d = '0;
                    first_d    = 1'b1;
                end
            endcase
        end
    end

    // Outputs: ready withheld during reset and clear so no handshake completes
    // without the sample actually entering the chain
    always_comb begin
        in_ready   = 1'b0;
        shift_en   = 1'b0;
        shift_data = in_data;
        case (state_q)
            S_FILL: begin
                in_ready = rst & ~clear;
                shift_en = in_valid & rst & ~clear;
            end
`ifdef ZERO_FLUSH_EN
            S_FLUSH: begin
                shift_en   = rst & ~clear;
                shift_data = '0;
            end
`endif
            default: begin
                in_ready = 1'b0;
                shift_en = 1'b0;
            end
        endcase
    end

    assign win_valid = (state_q == S_HOLD);
    assign busy      = (state_q != S_FILL);
    assign fill_cnt  = fill_cnt_q;
    assign win_count = win_count_q;

endmodule
